// File: rtl/receiver_pkg.sv
// receiver_pkg: shared definitions for the UART receive path.
//   rx_state_t        - receiver FSM states
//   DATA_BITS         - payload bits per frame (8N1)
//   DEFAULT_COUNT_MAX - bit period minus one in CLK cycles; the byte
//                       transmitter imports this same constant so both
//                       ends agree on the baud rate.
//   maj3              - 2-of-3 majority vote
package receiver_pkg;

    localparam int unsigned DATA_BITS         = 8;
    localparam logic [8:0]  DEFAULT_COUNT_MAX = 9'd259;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/receiver_sync2.sv
// receiver_sync2: two-flop synchronizer for an asynchronous input.
// Resets to 1 so an idle-high line does not look like a start edge.
//   CLK - system clock
//   RST - asynchronous, active-high reset
//   d   - asynchronous input
//   q   - synchronized output
module receiver_sync2 (
    input  logic CLK,
    input  logic RST,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/receiver.sv
// receiver: UART receive end (8N1, LSB first, idle-high line).
// Samples the synchronized line at mid-bit with a bit-period counter and
// presents each byte on a valid/ready handshake.
//   CLK       - system clock
//   RST       - asynchronous, active-high reset
//   in        - serial RX line (asynchronous, idle high)
//   out       - received byte, stable while valid=1
//   valid     - out holds an unconsumed byte
//   ready     - consumer takes out when valid && ready at a CLK edge
//   frame_err - one-cycle pulse: stop bit sampled 0
//   overrun   - one-cycle pulse: completed byte dropped, holding reg full
// Build option: define RECEIVER_MAJORITY_EN for 2-of-3 majority sampling
// around each sample point (requires COUNT_MAX >= 4).
module receiver
    import receiver_pkg::*;
#(
    parameter int unsigned             COUNT_WIDTH = 9,
    parameter logic [COUNT_WIDTH-1:0]  COUNT_MAX   = COUNT_WIDTH'(DEFAULT_COUNT_MAX)
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       in,
    output logic [7:0] out,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam logic [COUNT_WIDTH-1:0] HALF = COUNT_MAX >> 1;

`ifdef RECEIVER_MAJORITY_EN
    // Votes are taken at target-1, target, target+1 and acted on at
    // target+1. For data/stop bits the target is COUNT_MAX, so target+1
    // is the wrapped count 0; restarting from 1 keeps the period at
    // COUNT_MAX+1 without the counter ever exceeding COUNT_MAX.
    localparam logic [COUNT_WIDTH-1:0] START_PT = HALF + 1'b1;
    localparam logic [COUNT_WIDTH-1:0] BIT_PT   = '0;
    localparam logic [COUNT_WIDTH-1:0] RESTART  = COUNT_WIDTH'(1);
`else
    localparam logic [COUNT_WIDTH-1:0] START_PT = HALF;
    localparam logic [COUNT_WIDTH-1:0] BIT_PT   = COUNT_MAX;
    localparam logic [COUNT_WIDTH-1:0] RESTART  = '0;
`endif

    rx_state_t              state;
    logic [COUNT_WIDTH-1:0] cnt;
    logic [COUNT_WIDTH-1:0] cnt_next;
    logic [2:0]             bit_idx;
    logic [7:0]             shift;
    logic                   rxs;
    logic                   sample;
    logic                   start_pt;
    logic                   bit_pt;
    logic                   complete;

    receiver_sync2 u_sync (
        .CLK (CLK),
        .RST (RST),
        .d   (in),
        .q   (rxs)
    );

`ifdef RECEIVER_MAJORITY_EN
    // hist[1] / hist[0] hold rxs from two cycles / one cycle ago.
    logic [1:0] hist;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) hist <= '1;
        else     hist <= {hist[0], rxs};
    end

    always_comb begin
        sample = maj3(hist[1], hist[0], rxs);
    end
`else
    always_comb begin
        sample = rxs;
    end
`endif

    always_comb begin
        start_pt = (state == START) && (cnt == START_PT);
        bit_pt   = ((state == DATA) || (state == STOP)) && (cnt == BIT_PT);
        complete = (state == STOP) && bit_pt && sample;
        cnt_next = (cnt == COUNT_MAX) ? '0 : cnt + 1'b1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            out       <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rxs) state <= START;
                end
                START: begin
                    if (start_pt) begin
                        if (sample) begin
                            // Line back high at mid start bit: glitch.
                            cnt   <= '0;
                            state <= IDLE;
                        end else begin
                            cnt     <= RESTART;
                            bit_idx <= '0;
                            state   <= DATA;
                        end
                    end else begin
                        cnt <= cnt_next;
                    end
                end
                DATA: begin
                    if (bit_pt) begin
                        shift[bit_idx] <= sample;
                        cnt            <= RESTART;
                        if (bit_idx == 3'(DATA_BITS - 1)) state   <= STOP;
                        else                               bit_idx <= bit_idx + 1'b1;
                    end else begin
                        cnt <= cnt_next;
                    end
                end
                STOP: begin
                    if (bit_pt) begin
                        cnt <= '0;
                        if (sample) begin
                            state <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt_next;
                    end
                end
                WAIT_HIGH: begin
                    // A held-low break yields one frame_err, not one per frame time.
                    cnt <= '0;
                    if (rxs) state <= IDLE;
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase

            // A consume and a completion in the same cycle hand over directly,
            // so valid stays high across back-to-back bytes.
            if (complete) begin
                if (!valid || ready) begin
                    out   <= shift;
                    valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule
